// File: rtl/bus_sequencer_if.sv
// Backplane request/grant bundle between the bus masters and the bus sequencer.
// The master modport is the sequencer side (drives grants); slave is the requesting side.
interface bus_sequencer_if;
    logic       cslREQI;
    logic [0:3] ubaREQI;
    logic       cpuREQI;
    logic       busACKI;
    logic       cslGNTO;
    logic [0:3] ubaGNTO;
    logic       cpuGNTO;
    logic       arbBUSYO;
    logic       arbNXMO;
    logic [0:2] arbNXMSRCO;

    modport master (
        input  cslREQI, ubaREQI, cpuREQI, busACKI,
        output cslGNTO, ubaGNTO, cpuGNTO, arbBUSYO, arbNXMO, arbNXMSRCO
    );

    modport slave (
        output cslREQI, ubaREQI, cpuREQI, busACKI,
        input  cslGNTO, ubaGNTO, cpuGNTO, arbBUSYO, arbNXMO, arbNXMSRCO
    );
endinterface

// File: rtl/bus_sequencer.sv
// KS10 bus-ownership sequencer: registered one-hot grants held per transaction,
// round-robin among Unibus adapters, NXM timeout on unacknowledged cycles.
module bus_sequencer #(
    parameter int unsigned TIMEOUT = 64
) (
    input logic           clk,
    input logic           rst,
    bus_sequencer_if.master bus
);
    typedef enum logic [1:0] {IDLE, BUSY, RELEASE} state_t;

    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

    state_t     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic [1:0] ptr_q, ptr_d;
    logic [1:6] gnt_q, gnt_d;       // index = master code: 1 csl, 2..5 uba0..3, 6 cpu
    logic       nxm_q, nxm_d;
    logic [2:0] nxm_src_q, nxm_src_d;

    logic [1:6] req;
    logic       win_valid;
    logic [2:0] win_code;
    logic [1:0] rr_idx;
    logic [2:0] own_code;
    logic       own_req;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            ptr_q     <= '0;
            gnt_q     <= '0;
            nxm_q     <= 1'b0;
            nxm_src_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            ptr_q     <= ptr_d;
            gnt_q     <= gnt_d;
            nxm_q     <= nxm_d;
            nxm_src_q <= nxm_src_d;
        end
    end

    always_comb begin
        req       = {bus.cslREQI, bus.ubaREQI, bus.cpuREQI};
        win_valid = 1'b0;
        win_code  = '0;
        rr_idx    = '0;
        if (req[1]) begin
            win_valid = 1'b1;
            win_code  = 3'd1;
        end else begin
            for (int unsigned i = 0; i < 4; i++) begin
                rr_idx = ptr_q + 2'(i);
                if (!win_valid && bus.ubaREQI[rr_idx]) begin
                    win_valid = 1'b1;
                    win_code  = 3'd2 + {1'b0, rr_idx};
                end
            end
            if (!win_valid && req[6]) begin
                win_valid = 1'b1;
                win_code  = 3'd6;
            end
        end

        own_code = '0;
        for (int unsigned c = 1; c <= 6; c++) begin
            if (gnt_q[c]) own_code = 3'(c);
        end
        own_req = |(gnt_q & req);
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        ptr_d     = ptr_q;
        gnt_d     = gnt_q;
        nxm_d     = 1'b0;
        nxm_src_d = nxm_src_q;
        unique case (state_q)
            IDLE: begin
                if (win_valid) begin
                    state_d = BUSY;
                    cnt_d   = '0;
                    gnt_d   = 6'b100000 >> (win_code - 3'd1);
                    // uba code n+2 minus one is exactly (n+1) mod 4 after truncation
                    if (win_code >= 3'd2 && win_code <= 3'd5) ptr_d = 2'(win_code - 3'd1);
                end
            end
            BUSY: begin
                if (cnt_q != 8'hFF) cnt_d = cnt_q + 8'd1;
                if (bus.busACKI || !own_req) begin
                    state_d = RELEASE;
                    gnt_d   = '0;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    state_d   = RELEASE;
                    gnt_d     = '0;
                    nxm_d     = 1'b1;
                    nxm_src_d = own_code;
                end
            end
            RELEASE: begin
                state_d = IDLE;
                gnt_d   = '0;
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        bus.cslGNTO    = gnt_q[1];
        bus.ubaGNTO    = gnt_q[2:5];
        bus.cpuGNTO    = gnt_q[6];
        bus.arbBUSYO   = (state_q != IDLE);
        bus.arbNXMO    = nxm_q;
        bus.arbNXMSRCO = nxm_src_q;
    end
endmodule

// File: tb/tb_bus_sequencer.sv
// Directed bench for bus_sequencer with TIMEOUT=4; outputs sampled on the falling edge.
module tb_bus_sequencer;
    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  reqs;          // {csl, uba0, uba1, uba2, uba3, cpu}
    logic [10:0] outs;          // {csl, uba0..3, cpu grants, busy, nxm, nxm_src}
    logic [10:0] e;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    bus_sequencer_if bus ();

    bus_sequencer #(.TIMEOUT(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always_comb begin
        bus.cslREQI = reqs[5];
        bus.ubaREQI = reqs[4:1];
        bus.cpuREQI = reqs[0];
        outs = {bus.cslGNTO, bus.ubaGNTO, bus.cpuGNTO, bus.arbBUSYO, bus.arbNXMO, bus.arbNXMSRCO};
    end

    task automatic step;
        @(negedge clk);
    endtask

    task automatic test_reset;
        rst = 1'b1; reqs = '0; bus.busACKI = 1'b0;
        step; step;
        e = '0;
        checks++; if (outs !== e) begin errors++; $display("FAIL reset_state: got %b expected %b", outs, e); end
        reqs = 6'b111111;
        step;
        checks++; if (outs !== e) begin errors++; $display("FAIL reset_overrides_req: got %b expected %b", outs, e); end
        rst = 1'b0; reqs = '0;
        step;
        checks++; if (outs !== e) begin errors++; $display("FAIL idle_no_req: got %b expected %b", outs, e); end
    endtask

    task automatic test_priority;
        logic [5:0] g;
        reqs = 6'b111111;
        for (int i = 0; i < 6; i++) begin
            g = 6'b100000 >> i;
            step;
            e = {g, 1'b1, 1'b0, 3'd0};
            checks++; if (outs !== e) begin errors++; $display("FAIL prio_grant[%0d]: got %b expected %b", i, outs, e); end
            step;
            checks++; if (outs !== e) begin errors++; $display("FAIL prio_hold[%0d]: got %b expected %b", i, outs, e); end
            bus.busACKI = 1'b1; reqs = reqs & ~g;
            step;
            e = {6'b0, 1'b1, 1'b0, 3'd0};
            checks++; if (outs !== e) begin errors++; $display("FAIL prio_release[%0d]: got %b expected %b", i, outs, e); end
            bus.busACKI = 1'b0;
            step;
            e = '0;
            checks++; if (outs !== e) begin errors++; $display("FAIL prio_idle[%0d]: got %b expected %b", i, outs, e); end
        end
    endtask

    task automatic test_rr_wrap;
        logic [5:0] add [3];
        logic [5:0] g   [3];
        add = '{6'b000010, 6'b010010, 6'b000000};
        g   = '{6'b000010, 6'b010000, 6'b000010};
        for (int i = 0; i < 3; i++) begin
            reqs = reqs | add[i];
            step;
            e = {g[i], 1'b1, 1'b0, 3'd0};
            checks++; if (outs !== e) begin errors++; $display("FAIL rr_grant[%0d]: got %b expected %b", i, outs, e); end
            bus.busACKI = 1'b1; reqs = reqs & ~g[i];
            step;
            e = {6'b0, 1'b1, 1'b0, 3'd0};
            checks++; if (outs !== e) begin errors++; $display("FAIL rr_release[%0d]: got %b expected %b", i, outs, e); end
            bus.busACKI = 1'b0;
            step;
        end
    endtask

    task automatic test_timeout;
        reqs = 6'b000001;
        for (int i = 0; i < 4; i++) begin
            step;
            e = {6'b000001, 1'b1, 1'b0, 3'd0};
            checks++; if (outs !== e) begin errors++; $display("FAIL timeout_grant_cycle[%0d]: got %b expected %b", i, outs, e); end
        end
        step;
        e = {6'b0, 1'b1, 1'b1, 3'd6};
        checks++; if (outs !== e) begin errors++; $display("FAIL timeout_nxm: got %b expected %b", outs, e); end
        reqs = '0;
        step;
        e = {6'b0, 1'b0, 1'b0, 3'd6};
        checks++; if (outs !== e) begin errors++; $display("FAIL timeout_after: got %b expected %b", outs, e); end
    endtask

    task automatic test_ack_at_timeout;
        reqs = 6'b001000;
        for (int i = 0; i < 4; i++) begin
            step;
            e = {6'b001000, 1'b1, 1'b0, 3'd6};
            checks++; if (outs !== e) begin errors++; $display("FAIL ackto_grant_cycle[%0d]: got %b expected %b", i, outs, e); end
        end
        bus.busACKI = 1'b1;
        step;
        e = {6'b0, 1'b1, 1'b0, 3'd6};
        checks++; if (outs !== e) begin errors++; $display("FAIL ackto_release_no_nxm: got %b expected %b", outs, e); end
        bus.busACKI = 1'b0; reqs = '0;
        step;
        e = {6'b0, 1'b0, 1'b0, 3'd6};
        checks++; if (outs !== e) begin errors++; $display("FAIL ackto_idle: got %b expected %b", outs, e); end
    endtask

    task automatic test_abort;
        reqs = 6'b001100;
        for (int i = 0; i < 3; i++) begin
            step;
            e = {6'b000100, 1'b1, 1'b0, 3'd6};
            checks++; if (outs !== e) begin errors++; $display("FAIL abort_grant_cycle[%0d]: got %b expected %b", i, outs, e); end
        end
        reqs = 6'b001000;
        step;
        e = {6'b0, 1'b1, 1'b0, 3'd6};
        checks++; if (outs !== e) begin errors++; $display("FAIL abort_release: got %b expected %b", outs, e); end
        step;
        e = {6'b0, 1'b0, 1'b0, 3'd6};
        checks++; if (outs !== e) begin errors++; $display("FAIL abort_idle: got %b expected %b", outs, e); end
        reqs = 6'b000110;
        step;
        e = {6'b000010, 1'b1, 1'b0, 3'd6};
        checks++; if (outs !== e) begin errors++; $display("FAIL abort_pointer: got %b expected %b", outs, e); end
        bus.busACKI = 1'b1; reqs = '0;
        step;
        bus.busACKI = 1'b0;
        step;
    endtask

    task automatic test_reset_busy;
        reqs = 6'b001000;
        step;
        e = {6'b001000, 1'b1, 1'b0, 3'd6};
        checks++; if (outs !== e) begin errors++; $display("FAIL rstbusy_grant: got %b expected %b", outs, e); end
        rst = 1'b1;
        step;
        e = '0;
        checks++; if (outs !== e) begin errors++; $display("FAIL rstbusy_cleared: got %b expected %b", outs, e); end
        rst = 1'b0; reqs = 6'b001100;
        step;
        e = {6'b001000, 1'b1, 1'b0, 3'd0};
        checks++; if (outs !== e) begin errors++; $display("FAIL rstbusy_ptr_reset: got %b expected %b", outs, e); end
        bus.busACKI = 1'b1; reqs = 6'b000100;
        step;
        e = {6'b0, 1'b1, 1'b0, 3'd0};
        checks++; if (outs !== e) begin errors++; $display("FAIL b2b_release: got %b expected %b", outs, e); end
        bus.busACKI = 1'b0;
        step;
        e = '0;
        checks++; if (outs !== e) begin errors++; $display("FAIL b2b_idle_gap: got %b expected %b", outs, e); end
        step;
        e = {6'b000100, 1'b1, 1'b0, 3'd0};
        checks++; if (outs !== e) begin errors++; $display("FAIL b2b_next_grant: got %b expected %b", outs, e); end
        bus.busACKI = 1'b1; reqs = '0;
        step;
        bus.busACKI = 1'b0;
        step;
        e = '0;
        checks++; if (outs !== e) begin errors++; $display("FAIL b2b_final_idle: got %b expected %b", outs, e); end
    endtask

    initial begin
        rst = 1'b1;
        reqs = '0;
        bus.busACKI = 1'b0;
        test_reset;
        test_priority;
        test_rr_wrap;
        test_timeout;
        test_ack_at_timeout;
        test_abort;
        test_reset_busy;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
